// File: rtl/amba_mem_arbiter.sv
// amba_mem_arbiter: two-master / one-slave arbiter for the shared memory slave.
// M0 is the instruction-fetch port (read only), M1 the load/store port (read
// and write). One transaction owns the slave at a time; a watchdog aborts a
// grant that the slave never completes and returns an error to the owner.
//
// Build option: ARB_ROUND_ROBIN_EN
//   defined   - under contention the master that was not the last owner wins
//   undefined - fixed priority, M1 always beats M0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; sample requests and pick the next owner
// RD0   | M0 read owns the slave read channels
// RD1   | M1 read owns the slave read channels
// WR1   | M1 write owns the slave write channels
module amba_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Aclk,
    input  logic              Areset,

    input  logic [ADDR_W-1:0] M0_ARAddr,
    input  logic              M0_ARValid,
    output logic              M0_ARReady,
    output logic [DATA_W-1:0] M0_RData,
    output logic              M0_RValid,
    input  logic              M0_RReady,

    input  logic [ADDR_W-1:0] M1_ARAddr,
    input  logic              M1_ARValid,
    output logic              M1_ARReady,
    output logic [DATA_W-1:0] M1_RData,
    output logic              M1_RValid,
    input  logic              M1_RReady,

    input  logic [ADDR_W-1:0] M1_AWAddr,
    input  logic              M1_AWValid,
    output logic              M1_AWReady,
    input  logic [DATA_W-1:0] M1_WData,
    input  logic              M1_WValid,
    output logic              M1_WReady,
    output logic              M1_BValid,
    output logic              M1_BResp,
    input  logic              M1_BReady,

    output logic [ADDR_W-1:0] S_ARAddr,
    output logic              S_ARValid,
    input  logic              S_ARReady,
    input  logic [DATA_W-1:0] S_RData,
    input  logic              S_RValid,
    output logic              S_RReady,

    output logic [ADDR_W-1:0] S_AWAddr,
    output logic              S_AWValid,
    input  logic              S_AWReady,
    output logic [DATA_W-1:0] S_WData,
    output logic              S_WValid,
    input  logic              S_WReady,
    input  logic              S_BValid,
    input  logic              S_BResp,
    output logic              S_BReady,

    output logic [1:0]        grant,
    output logic              timeout_err
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Watchdog is 8 bits wide, enough for the largest supported TIMEOUT.
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_WR1  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] wdog_q;
    logic       last_owner_q;     // 0: M0 owned last, 1: M1 owned last
    logic       timeout_err_q;
    logic       err_rd0_q, err_rd1_q, err_wr1_q;
    logic       xfer_done;
    logic       wdog_expire;
    logic       m1_req;
    logic       m1_wins;

    assign m1_req  = M1_ARValid | M1_AWValid;
    // With round robin, M0 takes the contended grant only when M1 owned last.
    assign m1_wins = m1_req & ~(M0_ARValid & RR_EN & last_owner_q);

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // State register.
    always_ff @(posedge Aclk or posedge Areset) begin
        if (Areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitration in IDLE, completion or watchdog abort when granted.
    always_comb begin
        state_d     = state_q;
        xfer_done   = 1'b0;
        wdog_expire = 1'b0;
        grant_d     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (m1_wins) begin
                    // A simultaneous M1 read and write: read first, the write
                    // stays requested and is picked up by the next grant.
                    state_d = M1_ARValid ? ST_RD1 : ST_WR1;
                end else if (M0_ARValid) begin
                    state_d = ST_RD0;
                end
            end
            ST_RD0:  xfer_done = S_RValid & M0_RReady;
            ST_RD1:  xfer_done = S_RValid & M1_RReady;
            ST_WR1:  xfer_done = S_BValid & M1_BReady;
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
            if (xfer_done) begin
                state_d = ST_IDLE;
            end else if (wdog_q == WDOG_LIMIT) begin
                state_d     = ST_IDLE;
                wdog_expire = 1'b1;
            end
        end
        case (state_d)
            ST_RD0:         grant_d = 2'b01;
            ST_RD1, ST_WR1: grant_d = 2'b10;
            default:        grant_d = 2'b00;
        endcase
    end

    // Grant, watchdog, last owner and the one-cycle abort response flags.
    always_ff @(posedge Aclk or posedge Areset) begin
        if (Areset) begin
            grant_q       <= 2'b00;
            wdog_q        <= 8'd0;
            last_owner_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            err_rd0_q     <= 1'b0;
            err_rd1_q     <= 1'b0;
            err_wr1_q     <= 1'b0;
        end else begin
            grant_q <= grant_d;
            if (state_q == ST_IDLE || state_d == ST_IDLE) begin
                wdog_q <= 8'd0;
            end else begin
                wdog_q <= wdog_q + 8'd1;
            end
            if (state_q != ST_IDLE && state_d == ST_IDLE) begin
                last_owner_q <= (state_q != ST_RD0);
            end
            timeout_err_q <= wdog_expire;
            err_rd0_q     <= wdog_expire & (state_q == ST_RD0);
            err_rd1_q     <= wdog_expire & (state_q == ST_RD1);
            err_wr1_q     <= wdog_expire & (state_q == ST_WR1);
        end
    end

    // Outputs: route only the owner's channels; everything else held at 0.
    always_comb begin
        M0_ARReady = 1'b0;
        M0_RData   = '0;
        M0_RValid  = 1'b0;
        M1_ARReady = 1'b0;
        M1_RData   = '0;
        M1_RValid  = 1'b0;
        M1_AWReady = 1'b0;
        M1_WReady  = 1'b0;
        M1_BValid  = 1'b0;
        M1_BResp   = 1'b0;
        S_ARAddr   = '0;
        S_ARValid  = 1'b0;
        S_RReady   = 1'b0;
        S_AWAddr   = '0;
        S_AWValid  = 1'b0;
        S_WData    = '0;
        S_WValid   = 1'b0;
        S_BReady   = 1'b0;
        case (state_q)
            ST_RD0: begin
                S_ARAddr   = M0_ARAddr;
                S_ARValid  = M0_ARValid;
                M0_ARReady = S_ARReady;
                M0_RData   = S_RData;
                M0_RValid  = S_RValid;
                S_RReady   = M0_RReady;
            end
            ST_RD1: begin
                S_ARAddr   = M1_ARAddr;
                S_ARValid  = M1_ARValid;
                M1_ARReady = S_ARReady;
                M1_RData   = S_RData;
                M1_RValid  = S_RValid;
                S_RReady   = M1_RReady;
            end
            ST_WR1: begin
                S_AWAddr   = M1_AWAddr;
                S_AWValid  = M1_AWValid;
                M1_AWReady = S_AWReady;
                S_WData    = M1_WData;
                S_WValid   = M1_WValid;
                M1_WReady  = S_WReady;
                M1_BValid  = S_BValid;
                M1_BResp   = S_BResp;
                S_BReady   = M1_BReady;
            end
            default: ;
        endcase
        // Abort responses land in the IDLE cycle after the watchdog fires,
        // so they never collide with routed traffic. They ignore Ready.
        if (err_rd0_q) begin
            M0_RValid = 1'b1;
            M0_RData  = {DATA_W{1'b1}};
        end
        if (err_rd1_q) begin
            M1_RValid = 1'b1;
            M1_RData  = {DATA_W{1'b1}};
        end
        if (err_wr1_q) begin
            M1_BValid = 1'b1;
            M1_BResp  = 1'b1;
        end
    end

endmodule

// File: tb/tb_amba_mem_arbiter.sv
// Self-checking bench for amba_mem_arbiter: behavioural slave memory,
// scoreboard queues for read data / write responses, a vector table for
// plain transactions and hand-written sequences for the corner cases.
module tb_amba_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic Aclk = 1'b0;
    logic Areset;
    logic [ADDR_W-1:0] M0_ARAddr, M1_ARAddr, M1_AWAddr, S_ARAddr, S_AWAddr;
    logic M0_ARValid, M0_ARReady, M0_RValid, M0_RReady;
    logic M1_ARValid, M1_ARReady, M1_RValid, M1_RReady;
    logic [DATA_W-1:0] M0_RData, M1_RData, M1_WData, S_RData, S_WData;
    logic M1_AWValid, M1_AWReady, M1_WValid, M1_WReady, M1_BValid, M1_BResp, M1_BReady;
    logic S_ARValid, S_ARReady, S_RValid, S_RReady;
    logic S_AWValid, S_AWReady, S_WValid, S_WReady, S_BValid, S_BResp, S_BReady;
    logic [1:0] grant;
    logic timeout_err;

    amba_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Aclk(Aclk), .Areset(Areset),
        .M0_ARAddr(M0_ARAddr), .M0_ARValid(M0_ARValid), .M0_ARReady(M0_ARReady),
        .M0_RData(M0_RData), .M0_RValid(M0_RValid), .M0_RReady(M0_RReady),
        .M1_ARAddr(M1_ARAddr), .M1_ARValid(M1_ARValid), .M1_ARReady(M1_ARReady),
        .M1_RData(M1_RData), .M1_RValid(M1_RValid), .M1_RReady(M1_RReady),
        .M1_AWAddr(M1_AWAddr), .M1_AWValid(M1_AWValid), .M1_AWReady(M1_AWReady),
        .M1_WData(M1_WData), .M1_WValid(M1_WValid), .M1_WReady(M1_WReady),
        .M1_BValid(M1_BValid), .M1_BResp(M1_BResp), .M1_BReady(M1_BReady),
        .S_ARAddr(S_ARAddr), .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
        .S_RData(S_RData), .S_RValid(S_RValid), .S_RReady(S_RReady),
        .S_AWAddr(S_AWAddr), .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
        .S_WData(S_WData), .S_WValid(S_WValid), .S_WReady(S_WReady),
        .S_BValid(S_BValid), .S_BResp(S_BResp), .S_BReady(S_BReady),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 Aclk = ~Aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tmo    = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic              qb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic              slave_mute, slave_flush;
    logic              rd_busy, aw_got, w_got;
    logic [DATA_W-1:0] rd_data_q, w_data_q;
    logic [7:0]        aw_addr_q;
    logic [DATA_W-1:0] mem [256];

    assign S_ARReady = !rd_busy;
    assign S_RValid  = rd_busy && !slave_mute;
    assign S_RData   = rd_data_q;
    assign S_AWReady = !aw_got;
    assign S_WReady  = !w_got;
    assign S_BValid  = aw_got && w_got && !slave_mute;
    assign S_BResp   = 1'b0;

    always @(posedge Aclk or posedge Areset) begin
        if (Areset) begin
            rd_busy   <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            rd_data_q <= '0;
            w_data_q  <= '0;
            aw_addr_q <= '0;
            mem[8'h03] <= 32'h0000_1234;
            mem[8'h20] <= 32'hC0DE_0020;
            mem[8'h24] <= 32'hC0DE_0024;
        end else if (slave_flush) begin
            rd_busy <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            if (S_ARValid && S_ARReady) begin
                rd_busy   <= 1'b1;
                rd_data_q <= mem[S_ARAddr[7:0]];
            end else if (S_RValid && S_RReady) begin
                rd_busy <= 1'b0;
            end
            if (S_AWValid && S_AWReady) begin
                aw_got    <= 1'b1;
                aw_addr_q <= S_AWAddr[7:0];
            end
            if (S_WValid && S_WReady) begin
                w_got    <= 1'b1;
                w_data_q <= S_WData;
            end
            if (S_BValid && S_BReady) begin
                mem[aw_addr_q] <= w_data_q;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard and bus invariants ----------------
    always @(negedge Aclk) begin
        if (!Areset) begin
            if (M0_RValid && M0_RReady) begin
                check("m0_rsp_pending", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) check("m0_rdata", M0_RData, q0.pop_front());
            end
            if (M1_RValid && M1_RReady) begin
                check("m1_rsp_pending", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) check("m1_rdata", M1_RData, q1.pop_front());
            end
            if (M1_BValid && M1_BReady) begin
                check("m1_bresp_pending", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) check("m1_bresp", M1_BResp, qb.pop_front());
            end
            check("bus_invariants",
                  {!$onehot0(grant),
                   S_ARValid && S_AWValid,
                   M0_ARReady && !grant[0],
                   (M1_ARReady || M1_AWReady || M1_WReady) && !grant[1],
                   (S_ARValid || S_AWValid || S_WValid || S_RReady || S_BReady) && (grant == 2'b00)},
                  64'd0);
            if (timeout_err) n_tmo++;
        end
    end

    // ---------------- master tasks ----------------
    task automatic m_read(input bit m, input logic [31:0] addr, input logic [31:0] exp_d,
                          output logic [1:0] g);
        bit hs, got;
        g = 2'b00;
        if (m) q1.push_back(exp_d); else q0.push_back(exp_d);
        @(posedge Aclk); #1;
        if (m) begin M1_ARAddr = addr; M1_ARValid = 1'b1; M1_RReady = 1'b1; end
        else   begin M0_ARAddr = addr; M0_ARValid = 1'b1; M0_RReady = 1'b1; end
        hs = 1'b0;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge Aclk);
            hs = m ? M1_ARReady : M0_ARReady;
            @(posedge Aclk); #1;
        end
        if (m) M1_ARValid = 1'b0; else M0_ARValid = 1'b0;
        check("m_read_ar_handshake", 64'(hs), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 60 && hs && !got; i++) begin
            @(negedge Aclk);
            got = m ? M1_RValid : M0_RValid;
            if (got) g = grant;
            @(posedge Aclk); #1;
        end
        check("m_read_rvalid_seen", 64'(got), 64'd1);
        if (m) M1_RReady = 1'b0; else M0_RReady = 1'b0;
    endtask

    task automatic m_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] g);
        bit a, w, got;
        g = 2'b00;
        qb.push_back(1'b0);
        @(posedge Aclk); #1;
        M1_AWAddr = addr; M1_AWValid = 1'b1;
        M1_WData  = data; M1_WValid  = 1'b1;
        M1_BReady = 1'b1;
        for (int i = 0; i < 60 && (M1_AWValid || M1_WValid); i++) begin
            @(negedge Aclk);
            a = M1_AWValid && M1_AWReady;
            w = M1_WValid && M1_WReady;
            @(posedge Aclk); #1;
            if (a) M1_AWValid = 1'b0;
            if (w) M1_WValid  = 1'b0;
        end
        check("m_write_aw_w_handshake", {M1_AWValid, M1_WValid}, 64'd0);
        M1_AWValid = 1'b0;
        M1_WValid  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge Aclk);
            got = M1_BValid;
            if (got) g = grant;
            @(posedge Aclk); #1;
        end
        check("m_write_bvalid_seen", 64'(got), 64'd1);
        M1_BReady = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;       // expected read data, or data written
        logic [1:0]  exp_grant;
    } vec_t;
    vec_t vecs[7];

    logic [1:0] g, g_rd, g_wr;
    logic [1:0] chan[2];
    logic [1:0] gseq[4];
    logic [1:0] exp_seq[4];
    logic [1:0] w_prev;
    int         w_k, ng, gcnt;
    bit         seen, hs0;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        Areset = 1'b1;
        slave_mute = 1'b0; slave_flush = 1'b0;
        M0_ARAddr = '0; M0_ARValid = 1'b0; M0_RReady = 1'b0;
        M1_ARAddr = '0; M1_ARValid = 1'b0; M1_RReady = 1'b0;
        M1_AWAddr = '0; M1_AWValid = 1'b0; M1_WData = '0; M1_WValid = 1'b0; M1_BReady = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h03, 32'h0000_1234, 2'b01};
        vecs[1] = '{1'b1, 1'b1, 32'h10, 32'h0000_00A5, 2'b10};
        vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0000_00A5, 2'b10};
        vecs[3] = '{1'b0, 1'b0, 32'h10, 32'h0000_00A5, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 32'h30, 32'hDEAD_BEEF, 2'b10};
        vecs[5] = '{1'b0, 1'b0, 32'h30, 32'hDEAD_BEEF, 2'b01};
        vecs[6] = '{1'b1, 1'b0, 32'h03, 32'h0000_1234, 2'b10};

        // Reset values.
        repeat (3) @(posedge Aclk);
        @(negedge Aclk);
        check("rst_ctrl", {grant, timeout_err, M0_ARReady, M0_RValid, M1_ARReady, M1_RValid,
                           M1_AWReady, M1_WReady, M1_BValid, M1_BResp, S_ARValid, S_RReady,
                           S_AWValid, S_WValid, S_BReady}, 64'd0);
        check("rst_addr", {S_ARAddr, S_AWAddr}, 64'd0);
        check("rst_data", {M0_RData, M1_RData}, 64'd0);
        check("rst_wdata", S_WData, 64'd0);
        @(posedge Aclk); #1;
        Areset = 1'b0;

        // Plain transactions from the table.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) m_write(vecs[i].addr, vecs[i].data, g);
            else            m_read(vecs[i].m, vecs[i].addr, vecs[i].data, g);
            check($sformatf("vec%0d_grant", i), g, vecs[i].exp_grant);
        end

        // M1 read and write requested together: read first, then write.
        w_prev = 2'b00; w_k = 0;
        chan[0] = 2'b00; chan[1] = 2'b00;
        fork
            m_read(1'b1, 32'h24, 32'hC0DE_0024, g_rd);
            m_write(32'h44, 32'h0000_005A, g_wr);
            begin
                for (int i = 0; i < 80 && w_k < 2; i++) begin
                    @(negedge Aclk);
                    if (grant != 2'b00 && w_prev == 2'b00) begin
                        chan[w_k] = {S_ARValid, S_AWValid};
                        w_k++;
                    end
                    w_prev = grant;
                end
            end
        join
        check("simul_first_is_read", chan[0], 2'b10);
        check("simul_second_is_write", chan[1], 2'b01);
        check("simul_rd_grant", g_rd, 2'b10);
        check("simul_wr_grant", g_wr, 2'b10);
        m_read(1'b0, 32'h44, 32'h0000_005A, g);
        check("simul_write_landed_grant", g, 2'b01);

        // Contention: both masters hold ARValid for four grants.
        for (int i = 0; i < 4; i++) begin
            exp_seq[i] = (RR && (i % 2 == 1)) ? 2'b01 : 2'b10;
            if (exp_seq[i] == 2'b01) q0.push_back(32'hC0DE_0020);
            else                     q1.push_back(32'hC0DE_0024);
            gseq[i] = 2'b00;
        end
        @(posedge Aclk); #1;
        M0_ARAddr = 32'h20; M0_ARValid = 1'b1; M0_RReady = 1'b1;
        M1_ARAddr = 32'h24; M1_ARValid = 1'b1; M1_RReady = 1'b1;
        ng = 0; w_prev = 2'b00;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge Aclk);
            if (grant != 2'b00 && w_prev == 2'b00) begin
                gseq[ng] = grant;
                ng++;
            end
            w_prev = grant;
        end
        @(posedge Aclk); #1;
        M0_ARValid = 1'b0; M1_ARValid = 1'b0;
        check("contention_grants_seen", 64'(ng), 64'd4);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Aclk);
            seen = (grant == 2'b00);
        end
        @(posedge Aclk); #1;
        M0_RReady = 1'b0; M1_RReady = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i), gseq[i], exp_seq[i]);

        // Watchdog: slave accepts the address but never returns data.
        slave_mute = 1'b1;
        @(posedge Aclk); #1;
        M0_ARAddr = 32'h08; M0_ARValid = 1'b1; M0_RReady = 1'b0;
        gcnt = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Aclk);
            if (timeout_err) seen = 1'b1;
            else begin
                if (grant == 2'b01) gcnt++;
                hs0 = M0_ARValid && M0_ARReady;
                @(posedge Aclk); #1;
                if (hs0) M0_ARValid = 1'b0;
            end
        end
        check("tmo_pulse_seen", 64'(seen), 64'd1);
        check("tmo_granted_cycles", 64'(gcnt), 64'(TIMEOUT));
        check("tmo_grant_cleared", grant, 2'b00);
        check("tmo_m0_rvalid", M0_RValid, 1'b1);
        check("tmo_m0_rdata", M0_RData, 32'hFFFF_FFFF);
        check("tmo_m1_rvalid", M1_RValid, 1'b0);
        @(posedge Aclk); #1;
        M0_ARValid = 1'b0;
        slave_mute = 1'b0;           // late slave data shows up while IDLE
        @(negedge Aclk);
        check("tmo_pulse_one_cycle", timeout_err, 1'b0);
        check("late_rvalid_dropped", M0_RValid, 1'b0);
        @(posedge Aclk); #1;
        slave_flush = 1'b1;
        @(posedge Aclk); #1;
        slave_flush = 1'b0;

        // Areset in the middle of a stalled write.
        slave_mute = 1'b1;
        @(posedge Aclk); #1;
        M1_AWAddr = 32'h50; M1_AWValid = 1'b1;
        M1_WData = 32'h0000_7777; M1_WValid = 1'b1; M1_BReady = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Aclk);
            seen = (grant == 2'b10);
        end
        check("rst_mid_wr1_granted", 64'(seen), 64'd1);
        @(negedge Aclk);
        @(negedge Aclk);
        #2 Areset = 1'b1;
        #1;
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_ctrl", {timeout_err, M0_ARReady, M0_RValid, M1_ARReady, M1_RValid,
                                 M1_AWReady, M1_WReady, M1_BValid, S_ARValid, S_RReady,
                                 S_AWValid, S_WValid, S_BReady}, 64'd0);
        check("async_rst_addr", {S_AWAddr, S_ARAddr}, 64'd0);
        check("async_rst_wdata", S_WData, 64'd0);
        M1_AWValid = 1'b0; M1_WValid = 1'b0; M1_BReady = 1'b0;
        slave_mute = 1'b0;
        @(posedge Aclk);
        @(posedge Aclk); #1;
        Areset = 1'b0;
        m_read(1'b0, 32'h03, 32'h0000_1234, g);
        check("post_rst_read_grant", g, 2'b01);

        repeat (3) @(posedge Aclk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("qb_drained", 64'(qb.size()), 64'd0);
        check("tmo_pulse_count", 64'(n_tmo), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amba_mem_arbiter.md
Name: amba_mem_arbiter

Overview:
- Two-master to one-slave arbiter for the shared AMBA-style memory slave.
- M0 is the CPU instruction-fetch port (read-only). M1 is the CPU load/store port (read and write).
- Grants the slave bus to exactly one transaction at a time, routes the channels, and tracks completion.
- A watchdog recovers from a slave that never completes.

Parameters:
ADDR_W, 32, address width of all address channels
DATA_W, 32, data width of all data channels
TIMEOUT, 16, cycles in a granted state without completion before abort (range 2..255)

Ports:
Aclk  in  1  bus clock, rising edge
Areset  in  1  asynchronous active-high reset
Mn_ARAddr, Mn_ARValid (n=0,1)  in  ADDR_W,1  master read-address request
Mn_ARReady (n=0,1)  out  1  read address accepted
Mn_RData, Mn_RValid (n=0,1)  out  DATA_W,1  read data return
Mn_RReady (n=0,1)  in  1  master read-data accept
M1_AWAddr, M1_AWValid  in  ADDR_W,1  write address request
M1_AWReady  out  1  write address accepted
M1_WData, M1_WValid  in  DATA_W,1  write data
M1_WReady  out  1  write data accepted
M1_BValid, M1_BResp  out  1,1  write response
M1_BReady  in  1  write response accept
S_ARAddr, S_ARValid, S_RReady  out  ADDR_W,1,1  to slave read channels
S_ARReady, S_RData, S_RValid  in  1,DATA_W,1  from slave read channels
S_AWAddr, S_AWValid, S_WData, S_WValid, S_BReady  out  ADDR_W,1,DATA_W,1,1  to slave write channels
S_AWReady, S_WReady, S_BValid, S_BResp  in  1,1,1,1  from slave write channels
grant  out  2  one-hot current owner (bit0=M0, bit1=M1), 0 when idle
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, RD0, RD1, WR1. State, grant, last-owner flag and watchdog counter are registered.
- Reset values:
  - state=IDLE, grant=0, timeout_err=0, watchdog=0, last owner=M0.
  - All master Ready/Valid outputs and all slave Valid/Ready outputs are 0.
  - All data/address outputs are 0.
- IDLE:
  - Samples requests M0_ARValid, M1_ARValid, M1_AWValid.
  - Picks the winner and moves to RDn/WR1 on the next edge.
  - Nothing is forwarded to the slave while in IDLE.
  - Arbitration latency is one cycle.
- M1 read and write requested together: read wins; the write is served in the following grant.
- Granted state: only the owner's channels are combinationally routed to the slave, and vice versa.
  - Non-owners see Ready=0 and Valid=0.
  - Slave outputs for unused channels are driven 0.
- A master's address/data must stay stable while its Valid is high. The arbiter never drops a request once it has sampled it.
- Completion:
  - RDn ends on the cycle S_RValid & Mn_RReady.
  - WR1 ends on the cycle S_BValid & M1_BReady.
  - Next state is IDLE, grant=0, last owner updated.
- Back-to-back grants: at least one IDLE cycle separates transactions.
- Watchdog:
  - Resets to 0 on entry to a granted state and increments each cycle in that state.
  - On reaching TIMEOUT without completion:
    - Forces IDLE and pulses timeout_err.
    - Drives a one-cycle error response to the owner: RDn gives Mn_RValid=1, Mn_RData=all ones; WR1 gives M1_BValid=1, M1_BResp=1.
  - The error response ignores Ready.
  - Completion and timeout in the same cycle: completion wins, no error.
- Slave Valid pulses arriving while IDLE (late after a timeout) are dropped.
- Areset mid-transaction: immediate return to reset values. No response is issued to the interrupted master.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both masters request in IDLE, grant goes to the master that was not the last owner. Write and read from M1 count as the same master.
- Undefined: fixed priority, M1 always beats M0. The last-owner flag is still kept but ignored.

Test Plan:
- Single read: M0 ARValid, ARAddr=0x3, slave returns 0x1234 -> grant=01 one cycle after request; M0_RValid with RData=0x1234; back to IDLE.
- M1 write then read: M1 writes 0xA5 to addr 16, then reads addr 16 -> M1_BValid seen once; read returns 0xA5; M0 Ready signals stay 0 throughout.
- Contention, macro undefined: M0 and M1 ARValid held continuously for 4 transactions -> grants M1,M1,M1,M1; M0 starved. With ARB_ROUND_ROBIN_EN: M1,M0,M1,M0.
- M1 simultaneous AW and AR -> read granted first, write second; slave sees no overlapping Valids.
- Timeout: slave never raises S_RValid -> after 16 granted cycles timeout_err=1 for one cycle, Mn_RValid=1, RData=0xFFFFFFFF, grant=0.
- Areset asserted mid-WR1 -> grant=0 and all Valid/Ready outputs 0 immediately (asynchronously); after release a new M0 read completes normally.
